// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap/mret sequencer driving the CSR trap channel and a single PC redirect.
// Latency: trap accept at T, CSR writes T+1..T+4, jump at T+5; mret writes at T+1, jumps at T+2.
// Backpressure: an execute-stage CSR write (idex_csr_we_i) stalls any write state one cycle; hold_o stalls the pipeline.
module trap_seq #(
  parameter bit VECTORED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_pc_i,
  input  logic [31:0] inst_npc_i,
  input  logic [31:0] inst_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        mret_i,
  input  logic        ex_trap_valid_i,
  input  logic        tcmp_trap_valid_i,
  input  logic        soft_trap_valid_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mepc_i,
  input  logic        idex_csr_we_i,
  output logic        trap_csr_we_o,
  output logic [11:0] trap_csr_addr_o,
  output logic [31:0] trap_csr_wdata_o,
  input  logic [31:0] trap_csr_rdata_i,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SOFT    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STAT,
    S_JUMP,
    S_R_STAT,
    S_R_JUMP
  } state_t;

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_jump;

  logic        w_idle;
  logic        w_exc;
  logic        w_int;
  logic        w_acc_trap;
  logic        w_acc_mret;
  logic [31:0] w_epc;
  logic [31:0] w_cause;
  logic [31:0] w_tval;
  logic [31:0] w_vec_base;
  logic [31:0] w_vec_off;

  // Requests are only looked at on an instruction boundary while idle; interrupts are already
  // masked by mie at the source and are gated here by the global enable.
  assign w_idle     = (r_state == S_IDLE);
  assign w_exc      = exc_illegal_i | exc_ebreak_i | exc_ecall_i;
  assign w_int      = mstatus_mie_i & (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
  assign w_acc_trap = w_idle & inst_valid_i & (w_exc | (~mret_i & w_int));
  assign w_acc_mret = w_idle & inst_valid_i & ~w_exc & mret_i;

  // Select cause/epc/tval for the winning trap source (exceptions before interrupts).
  always_comb begin
    w_cause = 32'd0;
    w_epc   = inst_pc_i;
    w_tval  = 32'd0;
    if (exc_illegal_i) begin
      w_cause = CAUSE_ILLEGAL;
      w_tval  = inst_i;
    end else if (exc_ebreak_i) begin
      w_cause = CAUSE_EBREAK;
      w_tval  = inst_pc_i;
    end else if (exc_ecall_i) begin
      w_cause = CAUSE_ECALL;
    end else begin
      // Interrupts resume at the next instruction, not the completing one.
      w_epc = inst_npc_i;
      if (ex_trap_valid_i) begin
        w_cause = CAUSE_EXT;
      end else if (soft_trap_valid_i) begin
        w_cause = CAUSE_SOFT;
      end else begin
        w_cause = CAUSE_TIMER;
      end
    end
  end

  // Sequencer state plus registered channel controls; write states only advance when the
  // execute stage is not using the CSR port, so the stalled write is simply repeated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_epc   <= 32'd0;
      r_cause <= 32'd0;
      r_tval  <= 32'd0;
      r_we    <= 1'b0;
      r_addr  <= 12'd0;
      r_wdata <= 32'd0;
      r_jump  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc_trap) begin
            r_state <= S_W_EPC;
            r_epc   <= w_epc;
            r_cause <= w_cause;
            r_tval  <= w_tval;
            r_we    <= 1'b1;
            r_addr  <= CSR_MEPC;
            r_wdata <= w_epc;
          end else if (w_acc_mret) begin
            r_state <= S_R_STAT;
            r_we    <= 1'b1;
            r_addr  <= CSR_MSTATUS;
            r_wdata <= 32'd0;
          end
        end
        S_W_EPC: begin
          if (!idex_csr_we_i) begin
            r_state <= S_W_CAUSE;
            r_addr  <= CSR_MCAUSE;
            r_wdata <= r_cause;
          end
        end
        S_W_CAUSE: begin
          if (!idex_csr_we_i) begin
            r_state <= S_W_TVAL;
            r_addr  <= CSR_MTVAL;
            r_wdata <= r_tval;
          end
        end
        S_W_TVAL: begin
          if (!idex_csr_we_i) begin
            r_state <= S_W_STAT;
            r_addr  <= CSR_MSTATUS;
            r_wdata <= 32'd0;
          end
        end
        S_W_STAT: begin
          if (!idex_csr_we_i) begin
            r_state <= S_JUMP;
            r_we    <= 1'b0;
            r_addr  <= CSR_MTVEC;
            r_wdata <= 32'd0;
            r_jump  <= 1'b1;
          end
        end
        S_JUMP: begin
          r_state <= S_IDLE;
          r_addr  <= 12'd0;
          r_jump  <= 1'b0;
        end
        S_R_STAT: begin
          if (!idex_csr_we_i) begin
            r_state <= S_R_JUMP;
            r_we    <= 1'b0;
            r_addr  <= 12'd0;
            r_wdata <= 32'd0;
            r_jump  <= 1'b1;
          end
        end
        S_R_JUMP: begin
          r_state <= S_IDLE;
          r_jump  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_addr  <= 12'd0;
          r_wdata <= 32'd0;
          r_jump  <= 1'b0;
        end
      endcase
    end
  end

  // Vector offset only applies to interrupts (cause[31]) in vectored mode; 32-bit wrap is intended.
  assign w_vec_base = {trap_csr_rdata_i[31:2], 2'b00};
  assign w_vec_off  = (VECTORED && r_cause[31]) ? {25'd0, r_cause[4:0], 2'b00} : 32'd0;

  // mstatus writes are read-modify-write against the live CSR value; other states use the latch.
  always_comb begin
    trap_csr_wdata_o = r_wdata;
    if (r_state == S_W_STAT) begin
      // MPIE <- MIE, MIE <- 0
      trap_csr_wdata_o = {24'd0, trap_csr_rdata_i[3], 7'd0};
    end else if (r_state == S_R_STAT) begin
      // MIE <- MPIE, MPIE <- 1
      trap_csr_wdata_o = {24'd0, 1'b1, 3'd0, trap_csr_rdata_i[7], 3'd0};
    end
  end

  // Redirect target: trap vector from mtvec on the channel, or mepc for mret.
  always_comb begin
    jump_addr_o = 32'd0;
    if (r_state == S_JUMP) begin
      jump_addr_o = w_vec_base + w_vec_off;
    end else if (r_state == S_R_JUMP) begin
      jump_addr_o = mepc_i;
    end
  end

  assign trap_csr_we_o   = r_we;
  assign trap_csr_addr_o = r_addr;
  assign jump_o          = r_jump;
  // Stall in the same cycle the request is seen, and release the cycle after the redirect.
  assign hold_o          = ~w_idle | w_acc_trap | w_acc_mret;

endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: scoreboard bench for trap_seq with directed scenarios and randomized traffic.
// Expected CSR writes and redirects (value and cycle) are queued at issue and checked by a monitor.
// A small CSR file model answers the trap channel combinationally.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic [31:0] inst_pc_i = 32'd0;
  logic [31:0] inst_npc_i = 32'd0;
  logic [31:0] inst_i = 32'd0;
  logic        exc_illegal_i = 1'b0;
  logic        exc_ebreak_i = 1'b0;
  logic        exc_ecall_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        ex_trap_valid_i = 1'b0;
  logic        tcmp_trap_valid_i = 1'b0;
  logic        soft_trap_valid_i = 1'b0;
  logic        mstatus_mie_i;
  logic [31:0] mepc_i;
  logic        idex_csr_we_i = 1'b0;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o;
  logic [31:0] trap_csr_rdata_i;
  logic        hold_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;

  // environment CSR file (written by the DUT channel and by "software")
  logic [31:0] e_mstatus, e_mtvec, e_mepc, e_mcause, e_mtval;
  // reference architectural state used to predict responses
  logic [31:0] m_mstatus = 32'd0, m_mtvec = 32'd0, m_mepc = 32'd0;

  typedef struct {
    bit          jmp;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  trap_seq #(.VECTORED(1'b1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inst_valid_i      (inst_valid_i),
    .inst_pc_i         (inst_pc_i),
    .inst_npc_i        (inst_npc_i),
    .inst_i            (inst_i),
    .exc_illegal_i     (exc_illegal_i),
    .exc_ebreak_i      (exc_ebreak_i),
    .exc_ecall_i       (exc_ecall_i),
    .mret_i            (mret_i),
    .ex_trap_valid_i   (ex_trap_valid_i),
    .tcmp_trap_valid_i (tcmp_trap_valid_i),
    .soft_trap_valid_i (soft_trap_valid_i),
    .mstatus_mie_i     (mstatus_mie_i),
    .mepc_i            (mepc_i),
    .idex_csr_we_i     (idex_csr_we_i),
    .trap_csr_we_o     (trap_csr_we_o),
    .trap_csr_addr_o   (trap_csr_addr_o),
    .trap_csr_wdata_o  (trap_csr_wdata_o),
    .trap_csr_rdata_i  (trap_csr_rdata_i),
    .hold_o            (hold_o),
    .jump_o            (jump_o),
    .jump_addr_o       (jump_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mstatus_mie_i = e_mstatus[3];
  assign mepc_i        = e_mepc;

  always_comb begin
    trap_csr_rdata_i = 32'd0;
    case (trap_csr_addr_o)
      12'h300: trap_csr_rdata_i = e_mstatus;
      12'h305: trap_csr_rdata_i = e_mtvec;
      12'h341: trap_csr_rdata_i = e_mepc;
      12'h342: trap_csr_rdata_i = e_mcause;
      12'h343: trap_csr_rdata_i = e_mtval;
      default: trap_csr_rdata_i = 32'd0;
    endcase
  end

  // CSR file: trap-channel writes commit only when the execute stage is not writing
  initial begin
    e_mstatus = 0; e_mtvec = 0; e_mepc = 0; e_mcause = 0; e_mtval = 0;
    forever begin
      @(posedge clk);
      if (rst_n && trap_csr_we_o && !idex_csr_we_i) begin
        case (trap_csr_addr_o)
          12'h300: e_mstatus <= trap_csr_wdata_o;
          12'h305: e_mtvec   <= trap_csr_wdata_o;
          12'h341: e_mepc    <= trap_csr_wdata_o;
          12'h342: e_mcause  <= trap_csr_wdata_o;
          12'h343: e_mtval   <= trap_csr_wdata_o;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_ev(input bit jmp, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got addr %h data %h, nothing expected (cycle %0d)",
               jmp ? "jump" : "write", a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk(jmp ? "event_kind_jump" : "event_kind_write", 32'(jmp), 32'(e.jmp));
    if (!jmp) chk("write_addr", 32'(a), 32'(e.addr));
    chk(jmp ? "jump_addr" : "write_data", d, e.data);
    chk("event_cycle", 32'(cyc), 32'(e.cyc));
  endtask

  // monitor: every committed channel write and every redirect is matched against the queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (trap_csr_we_o && !idex_csr_we_i) mon_ev(1'b0, trap_csr_addr_o, trap_csr_wdata_o);
      if (jump_o) mon_ev(1'b1, 12'h000, jump_addr_o);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    inst_valid_i = 0; exc_illegal_i = 0; exc_ebreak_i = 0; exc_ecall_i = 0; mret_i = 0;
    ex_trap_valid_i = 0; soft_trap_valid_i = 0; tcmp_trap_valid_i = 0;
  endtask

  // "software" CSR writes, only while the sequencer is idle
  task automatic sw_set(input logic [31:0] st, input logic [31:0] tv, input logic [31:0] ep);
    e_mstatus = st; e_mtvec = tv; e_mepc = ep;
    m_mstatus = st; m_mtvec = tv; m_mepc = ep;
  endtask

  function automatic void push(input bit j, input logic [11:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.jmp = j; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // One boundary request. k = index of the write that meets an execute-stage CSR write,
  // n = how many consecutive cycles that collision lasts (0 = none).
  task automatic run_txn(input bit vld, input bit ill, input bit ebk, input bit ecl, input bit mrt,
                         input bit ext, input bit sft, input bit tmr,
                         input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] ins,
                         input int k_in, input int n);
    bit acc, is_trap, noise;
    logic [31:0] cause, epc, tval, stat, tgt;
    int t0, last, k;
    acc = 0; is_trap = 0; cause = 0; epc = pc; tval = 0; last = 0; k = k_in;
    if (vld) begin
      if (ill)      begin is_trap = 1; cause = 2;  tval = ins; end
      else if (ebk) begin is_trap = 1; cause = 3;  tval = pc;  end
      else if (ecl) begin is_trap = 1; cause = 11; end
      else if (!mrt && m_mstatus[3] && (ext || sft || tmr)) begin
        is_trap = 1;
        epc = npc;
        cause = ext ? 32'h8000000B : (sft ? 32'h80000003 : 32'h80000007);
      end
      acc = is_trap || mrt;
    end
    step();
    t0 = cyc;
    inst_valid_i = vld; exc_illegal_i = ill; exc_ebreak_i = ebk; exc_ecall_i = ecl; mret_i = mrt;
    ex_trap_valid_i = ext; soft_trap_valid_i = sft; tcmp_trap_valid_i = tmr;
    inst_pc_i = pc; inst_npc_i = npc; inst_i = ins;
    if (is_trap) begin
      push(0, 12'h341, epc,   t0 + 1 + ((n > 0 && k <= 0) ? n : 0));
      push(0, 12'h342, cause, t0 + 2 + ((n > 0 && k <= 1) ? n : 0));
      push(0, 12'h343, tval,  t0 + 3 + ((n > 0 && k <= 2) ? n : 0));
      push(0, 12'h300, m_mstatus[3] ? 32'h80 : 32'h0, t0 + 4 + n);
      tgt = (m_mtvec & 32'hFFFFFFFC) + (cause[31] ? (cause % 32) * 4 : 0);
      push(1, 12'h000, tgt, t0 + 5 + n);
      last = 5 + n;
      m_mepc = epc;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (acc) begin
      k = 0;
      stat = 32'h80 + (m_mstatus[7] ? 32'h8 : 32'h0);
      push(0, 12'h300, stat, t0 + 1 + n);
      push(1, 12'h000, m_mepc, t0 + 2 + n);
      last = 2 + n;
      m_mstatus = stat;
    end
    #2 chk("hold_at_boundary", 32'(hold_o), 32'(acc));
    if (!acc) begin
      for (int c = 1; c <= 3; c++) begin
        step();
        clear_req();
        #2 chk("hold_not_taken", 32'(hold_o), 32'd0);
      end
      return;
    end
    for (int c = 1; c <= last + 1; c++) begin
      step();
      clear_req();
      idex_csr_we_i = (c >= 1 + k) && (c <= k + n);
      // requests while busy must be ignored
      noise = ($urandom % 2) == 1;
      if (c <= 2) begin
        inst_valid_i = noise; exc_illegal_i = noise; ex_trap_valid_i = noise;
      end
      #2;
      if (c == last)     chk("hold_at_jump",  32'(hold_o), 32'd1);
      if (c == last + 1) chk("hold_released", 32'(hold_o), 32'd0);
    end
    idex_csr_we_i = 0;
  endtask

  initial begin
    int t0;
    // reset state
    #3;
    chk("reset_hold",  32'(hold_o), 32'd0);
    chk("reset_we",    32'(trap_csr_we_o), 32'd0);
    chk("reset_addr",  32'(trap_csr_addr_o), 32'd0);
    chk("reset_wdata", trap_csr_wdata_o, 32'd0);
    chk("reset_jump",  32'(jump_o), 32'd0);
    chk("reset_jaddr", jump_addr_o, 32'd0);
    repeat (2) step();
    rst_n = 1;

    // illegal instruction: jump to 0x200
    sw_set(32'h8, 32'h201, 32'h0);
    run_txn(1, 1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h104, 32'hFFFFFFFF, 0, 0);
    // timer interrupt, vectored: jump to 0x101C
    sw_set(32'h8, 32'h1001, 32'h0);
    run_txn(1, 0, 0, 0, 0, 0, 0, 1, 32'h200, 32'h204, 32'h13, 0, 0);
    // simultaneous external + software + ecall -> ecall wins
    sw_set(32'h8, 32'h3000, 32'h0);
    run_txn(1, 0, 0, 1, 0, 1, 1, 0, 32'h40, 32'h44, 32'h73, 0, 0);
    // mret restores MIE from MPIE, then the external interrupt is taken
    run_txn(1, 0, 0, 0, 1, 1, 0, 0, 32'h3000, 32'h3004, 32'h30200073, 0, 0);
    run_txn(1, 0, 0, 0, 0, 1, 1, 0, 32'h44, 32'h48, 32'h13, 0, 0);
    // mret with mstatus 0x80, mepc 0x344
    sw_set(32'h80, 32'h3000, 32'h344);
    run_txn(1, 0, 0, 0, 1, 0, 0, 0, 32'h3010, 32'h3014, 32'h30200073, 0, 0);
    // collision in W_CAUSE for 2 cycles -> jump at T+7
    sw_set(32'h8, 32'h800, 32'h0);
    run_txn(1, 0, 1, 0, 0, 0, 0, 0, 32'h600, 32'h604, 32'h00100073, 1, 2);
    // MIE = 0: interrupt not taken
    sw_set(32'h0, 32'h800, 32'h0);
    run_txn(1, 0, 0, 0, 0, 1, 1, 1, 32'h700, 32'h704, 32'h13, 0, 0);

    // reset during W_TVAL
    sw_set(32'h8, 32'h400, 32'h0);
    step();
    t0 = cyc;
    inst_valid_i = 1; exc_illegal_i = 1; inst_pc_i = 32'h500; inst_npc_i = 32'h504; inst_i = 32'hDEAD;
    push(0, 12'h341, 32'h500, t0 + 1);
    push(0, 12'h342, 32'd2, t0 + 2);
    step(); clear_req();
    step(); step();
    #2 chk("we_in_w_tval", 32'(trap_csr_we_o), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_hold",  32'(hold_o), 32'd0);
    chk("rst_mid_we",    32'(trap_csr_we_o), 32'd0);
    chk("rst_mid_jump",  32'(jump_o), 32'd0);
    chk("rst_mid_addr",  32'(trap_csr_addr_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_no_jump", 32'(jump_o), 32'd0);
    end
    chk("rst_writes_before", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_mepc = 32'h500;
    rst_n = 1;
    step();
    chk("rst_idle_hold", 32'(hold_o), 32'd0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc;
      if ((i % 4) == 0)
        sw_set({24'd0, 1'($urandom % 2), 3'd0, 1'($urandom % 2), 3'd0},
               $urandom, {$urandom, 2'b00} >> 2);
      pc = $urandom & 32'hFFFFFFFC;
      run_txn(($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
              ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
              pc, pc + 4, $urandom, $urandom % 4, $urandom % 3);
    end

    repeat (5) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
# trap_seq

Machine-mode trap sequencer that owns the CSR file's trap access channel. It detects exceptions, masked interrupts and `mret` at instruction boundaries and stalls the pipeline. It then performs the required CSR read-modify-write sequence one access per cycle, and issues a single redirect to the trap vector or to `mepc`. It sits between the execute/writeback stage, the CSR block and the PC generator.

## Interface
- `VECTORED`, default 1: 1 = interrupts jump to `{mtvec[31:2],2'b00} + 4*code`; 0 = all traps jump to `{mtvec[31:2],2'b00}`.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset. Single clock domain; reset is asynchronous active-low.
- `inst_valid_i` in 1: an instruction completes this cycle (the boundary).
- `inst_pc_i` in 32: PC of the completing instruction.
- `inst_npc_i` in 32: PC the core would execute next.
- `inst_i` in 32: instruction word of the completing instruction.
- `exc_illegal_i`, `exc_ebreak_i`, `exc_ecall_i`, `mret_i` in 1 each: qualifiers of the completing instruction.
- `ex_trap_valid_i`, `tcmp_trap_valid_i`, `soft_trap_valid_i` in 1 each: interrupt requests, already masked by `mie`.
- `mstatus_mie_i` in 1: global interrupt enable.
- `mepc_i` in 32: current `mepc` value.
- `idex_csr_we_i` in 1: execute stage is writing a CSR this cycle; this write has priority over the trap channel.
- `trap_csr_we_o` out 1: trap channel write enable.
- `trap_csr_addr_o` out 12: trap channel address.
- `trap_csr_wdata_o` out 32: trap channel write data.
- `trap_csr_rdata_i` in 32: trap channel read data, combinational from `trap_csr_addr_o`.
- `hold_o` out 1: pipeline stall.
- `jump_o` out 1: one-cycle redirect pulse.
- `jump_addr_o` out 32: redirect target.

## Operation
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- **Request acceptance:** only in IDLE and only with `inst_valid_i=1`.
- **Priority:** exception > `mret` > interrupt.
  - Exception order: illegal > ebreak > ecall.
  - Interrupt order (requires `mstatus_mie_i=1`): external > software > timer.
- **Latched values on accept:**
  - illegal: cause = 2, epc = `inst_pc_i`, tval = `inst_i`.
  - ebreak: cause = 3, epc = `inst_pc_i`, tval = `inst_pc_i`.
  - ecall: cause = 11, epc = `inst_pc_i`, tval = 0.
  - Interrupts: cause = 0x8000000B / 0x80000003 / 0x80000007, epc = `inst_npc_i`, tval = 0.
- **Trap FSM:** IDLE → W_EPC → W_CAUSE → W_TVAL → W_STAT → JUMP → IDLE.
  - W_EPC, W_CAUSE, W_TVAL write the latched epc, cause and tval respectively.
  - W_STAT: addr = mstatus; wdata = 0 except bit7 = `trap_csr_rdata_i[3]` (MPIE ← MIE) and bit3 = 0.
  - JUMP: addr = mtvec, `jump_o` = 1, `we` = 0.
  - Target = `{rdata[31:2],2'b00}`, plus `cause[4:0]<<2` when `VECTORED=1` and cause[31] = 1.
  - All arithmetic is 32-bit with wrap.
- **Mret FSM:** IDLE → R_STAT → R_JUMP → IDLE.
  - R_STAT: addr = mstatus; wdata bit3 = `rdata[7]` (MIE ← MPIE), bit7 = 1, other bits 0.
  - R_JUMP: `jump_o` = 1, `jump_addr_o` = `mepc_i`.
- **Write stall:** in any write state, if `idex_csr_we_i=1`:
  - outputs are still driven, but the FSM does not advance (the write is retried);
  - JUMP and R_JUMP are unaffected.
- Unused trap-channel outputs are 0 (IDLE: `we` = 0, addr = 0, wdata = 0).

## Timing
- **Reset:** state IDLE, all latches 0, every output 0.
- **Mid-sequence reset:** asynchronous return to IDLE with outputs 0; no partial redirect.
- **Output registration:** all outputs are Moore decodes of registered state/latches, except `hold_o`.
- **`hold_o`:** `(state != IDLE) | accept`, where `accept` is combinational in IDLE. The pipeline therefore stalls in the same cycle the trap is seen, and `hold_o` deasserts the cycle after JUMP/R_JUMP.
- **Trap latency:** accept at cycle T; CSR writes at T+1..T+4; `jump_o` at T+5 (no stalls). Each `idex_csr_we_i` collision adds 1 cycle.
- **Mret latency:** accept at T, mstatus write at T+1, `jump_o` at T+2.
- **Requests arriving while not IDLE:** ignored. Interrupts are level-sensitive and are re-evaluated in IDLE.
- **After trap entry:** MIE = 0, so no nested interrupt is accepted until software or `mret` restores it.
- **Interrupt pending at `mret` completion:** taken on the first IDLE boundary with `mstatus_mie_i=1`, with epc = that instruction's `inst_npc_i`.
- **Simultaneous exception and interrupt:** the exception is taken; the interrupt is not lost at the source.

## Test plan
- **Illegal instruction.**
  - Stimulus: `inst_valid_i=1`, `exc_illegal_i=1`, pc = 0x100, inst = 0xFFFFFFFF, mtvec reads 0x201, MIE = 1.
  - Required writes: mepc = 0x100, mcause = 2, mtval = 0xFFFFFFFF, mstatus = 0x80.
  - Required redirect: `jump_o` at T+5 to 0x200.
- **Timer interrupt, `VECTORED=1`.**
  - Stimulus: `tcmp_trap_valid_i=1`, MIE = 1, npc = 0x204, mtvec = 0x1001.
  - Required response: mepc = 0x204, mcause = 0x80000007, mtval = 0; jump to 0x101C.
- **Simultaneous requests.**
  - Stimulus: external, software and `exc_ecall_i` all asserted in one cycle.
  - Required response: mcause = 11. After a subsequent `mret` with MPIE = 1, the external interrupt is taken with mcause = 0x8000000B.
- **`mret`.**
  - Stimulus: mstatus reads 0x80, `mepc_i` = 0x344.
  - Required response: mstatus written 0x88 at T+1; `jump_o` to 0x344 at T+2; `hold_o` high for exactly T..T+2.
- **Collision.**
  - Stimulus: `idex_csr_we_i=1` during W_CAUSE for 2 cycles.
  - Required response: W_CAUSE is held 3 cycles with identical outputs; `jump_o` at T+7; all CSR values are still correct.
- **Reset and masking.**
  - Stimulus: assert `rst_n=0` during W_TVAL.
  - Required response: immediately `hold_o=0` and `trap_csr_we_o=0`, no `jump_o`, state IDLE.
  - Additionally: with MIE = 0, an interrupt request gives `hold_o=0` and no CSR activity.
